// File: rtl/cmd_rx_pkg.sv
// cmd_rx_pkg: shared state enum, opcode constants and command type for the command receiver and decoder
package cmd_rx_pkg;
  typedef enum logic {IDLE, ARG} state_e;
  localparam int OPC_LONG_BIT = 7;
  localparam int N_ARG_BYTES = 4;
  typedef logic [39:0] cmd_t;
endpackage

// File: rtl/cmd_rx_tmo_cnt.sv
// tmo_cnt: saturating idle counter that flags the cycle in which it would reach TIMEOUT
module tmo_cnt #(
  parameter int TIMEOUT = 100000,
  parameter int TO_W = 17
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // clear wins over enable; hold at all-ones instead of wrapping
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/cmd_rx.sv
// cmd_rx: assembles short (1-byte) and long (opcode + 4 LSB-first argument bytes) commands with inter-byte timeout
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int TO_W = 17
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_data_i,
  output logic [39:0] cmd_o,
  output logic        exec_o,
  output logic        abort_o
);
  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  opc_q, opc_d;
  logic [31:0] arg_q, arg_d;
  cmd_t        cmd_q, cmd_d;
  logic        exec_q, exec_d;
  logic        abort_q, abort_d;
  logic        tmo_clr, tmo_en, tmo_exp;

  tmo_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_tmo (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_exp)
  );

  // next-state: a strobed byte always wins over the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opc_d   = opc_q;
    arg_d   = arg_q;
    cmd_d   = cmd_q;
    exec_d  = 1'b0;
    abort_d = 1'b0;
    tmo_clr = 1'b1;
    tmo_en  = 1'b0;
    if (state_q == IDLE) begin
      if (rx_stb_i && rx_data_i[OPC_LONG_BIT]) begin
        opc_d   = rx_data_i;
        arg_d   = '0;
        idx_d   = '0;
        state_d = ARG;
      end else if (rx_stb_i) begin
        cmd_d  = {rx_data_i, 32'h0};
        exec_d = 1'b1;
      end
    end else begin
      tmo_clr = rx_stb_i;
      tmo_en  = !rx_stb_i;
      if (rx_stb_i) begin
        arg_d[{idx_q, 3'b000} +: 8] = rx_data_i;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(N_ARG_BYTES - 1)) begin
          cmd_d   = {opc_q, rx_data_i, arg_q[23:0]};
          exec_d  = 1'b1;
          state_d = IDLE;
        end
      end else if (tmo_exp) begin
        opc_d   = '0;
        arg_d   = '0;
        idx_d   = '0;
        abort_d = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opc_q   <= '0;
      arg_q   <= '0;
      cmd_q   <= '0;
      exec_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opc_q   <= opc_d;
      arg_q   <= arg_d;
      cmd_q   <= cmd_d;
      exec_q  <= exec_d;
      abort_q <= abort_d;
    end

  assign cmd_o   = cmd_q;
  assign exec_o  = exec_q;
  assign abort_o = abort_q;
endmodule
